// File: rtl/reduce_accumulator_if.sv
// ============================================================================
// Module   : reduce_accumulator_if
// Purpose  : Command, element-stream, ALU and result bundle for reduce_accumulator.
//            REDUCE_ACCUMULATOR_BUSYCNT_EN adds the busy_cycles observation port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reduce_accumulator_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [1:0]  req_vSew;
    logic        req_sign;
    logic [31:0] req_scalar;
    logic        req_empty;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] alu_src_0;
    logic [31:0] alu_src_1;
    logic [3:0]  alu_opcode;
    logic [1:0]  alu_vSew;
    logic        alu_sign;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef REDUCE_ACCUMULATOR_BUSYCNT_EN
    logic [15:0] busy_cycles;
`endif

    modport slave (
`ifdef REDUCE_ACCUMULATOR_BUSYCNT_EN
        output busy_cycles,
`endif
        input  req_valid, req_opcode, req_vSew, req_sign, req_scalar, req_empty,
        output req_ready,
        input  in_valid, in_data, in_last,
        output in_ready,
        output alu_src_0, alu_src_1, alu_opcode, alu_vSew, alu_sign,
        input  alu_result,
        output out_valid, out_data,
        input  out_ready
    );

    modport master (
`ifdef REDUCE_ACCUMULATOR_BUSYCNT_EN
        input  busy_cycles,
`endif
        output req_valid, req_opcode, req_vSew, req_sign, req_scalar, req_empty,
        input  req_ready,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  alu_src_0, alu_src_1, alu_opcode, alu_vSew, alu_sign,
        output alu_result,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/reduce_accumulator.sv
// ============================================================================
// Module   : reduce_accumulator
// Purpose  : Drives an external combinational reduce ALU over a packed element
//            stream, folds the lanes, combines with the seed and returns one result.
//            Optional: REDUCE_ACCUMULATOR_BUSYCNT_EN adds a saturating busy counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_accumulator (
    input wire clock,
    input wire reset,
    reduce_accumulator_if.slave io
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_ACCUM = 3'd2,
        S_FOLD  = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] acc_q;
    logic [31:0] res_q;
    logic [31:0] scalar_q;
    logic [3:0]  opcode_q;
    logic [1:0]  vsew_q;
    logic        sign_q;
    logic        empty_q;
    logic [1:0]  fold_cnt_q;
    logic        req_ready_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [1:0]  w_sew_eff;
    logic [31:0] w_mask;
    logic [1:0]  w_fold_init;
    logic [31:0] w_src_0;
    logic [31:0] w_src_1;

    // Reserved sew encoding 3 behaves as 32-bit elements.
    assign w_sew_eff = (vsew_q == 2'd3) ? 2'd2 : vsew_q;

    always_comb begin
        w_mask      = 32'hFFFF_FFFF;
        w_fold_init = 2'd0;
        case (w_sew_eff)
            2'd0: begin
                w_mask      = 32'h0000_00FF;
                w_fold_init = 2'd2;
            end
            2'd1: begin
                w_mask      = 32'h0000_FFFF;
                w_fold_init = 2'd1;
            end
            default: begin
                w_mask      = 32'hFFFF_FFFF;
                w_fold_init = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_src_0 = 32'h0;
        w_src_1 = 32'h0;
        case (state_q)
            S_ACCUM: begin
                w_src_0 = acc_q;
                w_src_1 = io.in_data;
            end
            S_FOLD: begin
                // Upper half first; the byte step only exists for 8-bit elements.
                w_src_0 = acc_q;
                if (fold_cnt_q == 2'd2 || w_sew_eff == 2'd1)
                    w_src_1 = {16'h0, acc_q[31:16]};
                else
                    w_src_1 = {24'h0, acc_q[15:8]};
            end
            S_FINAL: begin
                w_src_0 = acc_q;
                w_src_1 = scalar_q;
            end
            default: begin
                w_src_0 = 32'h0;
                w_src_1 = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= 32'h0;
            res_q       <= 32'h0;
            scalar_q    <= 32'h0;
            opcode_q    <= 4'h0;
            vsew_q      <= 2'd0;
            sign_q      <= 1'b0;
            empty_q     <= 1'b0;
            fold_cnt_q  <= 2'd0;
            req_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.req_valid) begin
                        opcode_q    <= io.req_opcode;
                        vsew_q      <= io.req_vSew;
                        sign_q      <= io.req_sign;
                        scalar_q    <= io.req_scalar;
                        empty_q     <= io.req_empty;
                        req_ready_q <= 1'b0;
                        if (io.req_empty) begin
                            acc_q      <= io.req_scalar;
                            fold_cnt_q <= 2'd0;
                            state_q    <= S_FINAL;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_FIRST;
                        end
                    end
                end
                S_FIRST, S_ACCUM: begin
                    if (io.in_valid) begin
                        acc_q <= (state_q == S_FIRST) ? io.in_data : io.alu_result;
                        if (io.in_last) begin
                            in_ready_q <= 1'b0;
                            fold_cnt_q <= w_fold_init;
                            state_q    <= (w_fold_init == 2'd0) ? S_FINAL : S_FOLD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_FOLD: begin
                    acc_q      <= io.alu_result;
                    fold_cnt_q <= fold_cnt_q - 2'd1;
                    if (fold_cnt_q == 2'd1)
                        state_q <= S_FINAL;
                end
                S_FINAL: begin
                    res_q       <= empty_q ? (scalar_q & w_mask) : (io.alu_result & w_mask);
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REDUCE_ACCUMULATOR_BUSYCNT_EN
    logic [15:0] busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 16'h0;
        end else if (state_q == S_IDLE && io.req_valid) begin
            busy_q <= 16'h0;
        end else if ((state_q == S_FIRST || state_q == S_ACCUM ||
                      state_q == S_FOLD  || state_q == S_FINAL) && busy_q != 16'hFFFF) begin
            busy_q <= busy_q + 16'd1;
        end
    end

    assign io.busy_cycles = busy_q;
`endif

    assign io.req_ready  = req_ready_q;
    assign io.in_ready   = in_ready_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_data   = res_q;
    assign io.alu_src_0  = w_src_0;
    assign io.alu_src_1  = w_src_1;
    assign io.alu_opcode = opcode_q;
    assign io.alu_vSew   = vsew_q;
    assign io.alu_sign   = sign_q;

endmodule

`default_nettype wire

// File: tb/tb_reduce_accumulator.sv
// ============================================================================
// Module   : tb_reduce_accumulator
// Purpose  : Self-checking bench for reduce_accumulator with a lane-wise ALU model
//            and an element-list reduction reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reduce_accumulator;

    logic clock = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   tick   = 0;
    int   t_acc  = 0;
    int   t_last = 0;
    logic [31:0] wq[$];
    logic [3:0]  c_ops [3] = '{4'd0, 4'd6, 4'd7};

    always #5 clock = ~clock;

    reduce_accumulator_if bus();

    reduce_accumulator dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    function automatic int sew_width(input logic [1:0] sew);
        return (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
    endfunction

    function automatic longint unsigned lane_op(input logic [3:0] op, input int w, input logic sgn,
                                                input longint unsigned a, input longint unsigned b);
        longint unsigned m;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        sa = (sgn && ((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (sgn && ((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (op)
            4'd0:    return (a + b) & m;
            4'd6:    return (sa <= sb) ? a : b;
            4'd7:    return (sa >= sb) ? a : b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op, input logic [1:0] sew, input logic sgn);
        int w;
        longint unsigned m, r;
        w = sew_width(sew);
        m = (64'd1 << w) - 64'd1;
        r = 64'd0;
        for (int l = 0; l < 32 / w; l++)
            r = r | (lane_op(op, w, sgn, (64'(a) >> (l * w)) & m, (64'(b) >> (l * w)) & m) << (l * w));
        return r[31:0];
    endfunction

    // Reference: reduce every element of the stream together with the seed.
    function automatic logic [31:0] ref_reduce(input logic [3:0] op, input logic [1:0] sew,
                                               input logic sgn, input logic [31:0] scal, input logic emp);
        int w;
        longint unsigned m, acc;
        w   = sew_width(sew);
        m   = (64'd1 << w) - 64'd1;
        acc = 64'(scal) & m;
        if (!emp)
            foreach (wq[i])
                for (int k = 0; k < 32 / w; k++)
                    acc = lane_op(op, w, sgn, acc, (64'(wq[i]) >> (k * w)) & m);
        return acc[31:0];
    endfunction

    assign bus.alu_result = alu_model(bus.alu_src_0, bus.alu_src_1, bus.alu_opcode,
                                      bus.alu_vSew, bus.alu_sign);

    task automatic step();
        @(posedge clock);
        #1;
        tick++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_req(input logic [3:0] op, input logic [1:0] sew, input logic sgn,
                             input logic [31:0] scal, input logic emp);
        int k = 0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_vSew   = sew;
        bus.req_sign   = sgn;
        bus.req_scalar = scal;
        bus.req_empty  = emp;
        while (!bus.req_ready && k < 20) begin
            step();
            k++;
        end
        check("req_ready", 32'(bus.req_ready), 32'd1);
        step();
        t_acc = tick - 1;
        // Scramble the command fields so only latched values can be used.
        bus.req_valid  = 1'b0;
        bus.req_opcode = 4'($urandom);
        bus.req_vSew   = 2'($urandom);
        bus.req_sign   = 1'($urandom);
        bus.req_scalar = $urandom;
        bus.req_empty  = 1'($urandom);
        check("alu_opcode", 32'(bus.alu_opcode), 32'(op));
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input int gap);
        int k = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            bus.in_last = 1'($urandom);
            bus.in_data = $urandom;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = last;
        while (!bus.in_ready && k < 20) begin
            step();
            k++;
        end
        check("in_ready", 32'(bus.in_ready), 32'd1);
        step();
        t_last       = tick - 1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic finish_cmd(input string tag, input logic [31:0] exp, input int exp_lat,
                              input int stall, input logic emp);
        int  k   = 0;
        bit  saw = 1'b0;
        int  t_ref;
        t_ref = emp ? t_acc : t_last;
        while (!bus.out_valid && k < 20) begin
            if (bus.in_ready) saw = 1'b1;
            step();
            k++;
        end
        check({tag, " latency"}, 32'(tick - t_ref), 32'(exp_lat));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " out_data"}, bus.out_data, exp);
        if (emp) check({tag, " in_ready_seen"}, 32'(saw), 32'd0);
`ifdef REDUCE_ACCUMULATOR_BUSYCNT_EN
        check({tag, " busy_cycles"}, 32'(bus.busy_cycles), 32'(tick - t_acc - 1));
`endif
        bus.out_ready = 1'b0;
        repeat (stall) begin
            step();
            check({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " stall out_data"}, bus.out_data, exp);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] sew,
                           input logic sgn, input logic [31:0] scal, input logic emp,
                           input logic [31:0] exp, input int gap_max, input int stall);
        int lat;
        lat = (sew == 2'd0) ? 4 : (sew == 2'd1) ? 3 : 2;
        issue_req(op, sew, sgn, scal, emp);
        if (!emp)
            foreach (wq[i])
                send_word(wq[i], (i == wq.size() - 1), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        finish_cmd(tag, exp, emp ? 2 : lat, stall, emp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [1:0]  sew;
        logic        sgn, emp;
        logic [31:0] scal;
        int          n;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 4'h0;
        bus.req_vSew   = 2'd0;
        bus.req_sign   = 1'b0;
        bus.req_scalar = 32'h0;
        bus.req_empty  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'h0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        step();
        step();
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", bus.out_data, 32'h0);
        check("rst alu_src_0", bus.alu_src_0, 32'h0);
        check("rst alu_src_1", bus.alu_src_1, 32'h0);
        check("rst alu_ctl", {25'h0, bus.alu_opcode, bus.alu_vSew, bus.alu_sign}, 32'h0);
        reset = 1'b0;
        step();

        wq = '{32'd5, 32'd7, 32'd9};
        run_cmd("add32", 4'd0, 2'd2, 1'b0, 32'd100, 1'b0, 32'd121, 0, 0);

        wq = '{32'h0403_0201};
        run_cmd("add8", 4'd0, 2'd0, 1'b0, 32'h0000_000A, 1'b0, 32'h0000_0014, 0, 1);

        wq = '{32'h0005_FFFE, 32'h7FFF_0003};
        run_cmd("smin16", 4'd6, 2'd1, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_FFFE, 0, 0);

        wq.delete();
        run_cmd("empty16", 4'd0, 2'd1, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_BEEF, 0, 0);

        wq = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_cmd("gaps_stall", 4'd0, 2'd2, 1'b0, 32'd1, 1'b0, 32'd101, 3, 5);

        // Abandon a command mid-stream with reset.
        issue_req(4'd0, 2'd2, 1'b0, 32'd50, 1'b0);
        send_word(32'd11, 1'b0, 0);
        send_word(32'd22, 1'b0, 0);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        reset = 1'b0;
        check("mid_rst req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst out_data", bus.out_data, 32'h0);
        check("mid_rst alu_src_0", bus.alu_src_0, 32'h0);
        check("mid_rst alu_ctl", {25'h0, bus.alu_opcode, bus.alu_vSew, bus.alu_sign}, 32'h0);
        wq = '{32'd3};
        run_cmd("after_rst", 4'd0, 2'd2, 1'b0, 32'd4, 1'b0, 32'd7, 0, 0);

        for (int r = 0; r < 40; r++) begin
            op   = c_ops[$urandom_range(0, 2)];
            sew  = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom);
            scal = $urandom;
            emp  = ($urandom_range(0, 7) == 0);
            n    = $urandom_range(1, 5);
            wq.delete();
            repeat (n) wq.push_back($urandom);
            run_cmd("rand", op, sew, sgn, scal, emp, ref_reduce(op, sew, sgn, scal, emp),
                    2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reduce_accumulator.md
# reduce_accumulator

Sequencing stage directly upstream of the combinational reduce ALU (add/min/max per element lane). It accepts a reduction command plus a stream of packed 32-bit element words, and iterates the ALU over the stream into a registered accumulator. It then folds the packed lanes down to one element, combines that element with the scalar seed, and returns a single zero-extended result. All ALU evaluations are single-cycle through the external combinational ALU; the block owns all state.

## Interface
Parameters: none; datapath fixed at 32 bits, 4 byte lanes.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  high only in IDLE
- req_opcode  in  4  ALU opcode (0 add, 6 min, 7 max); forwarded unchanged
- req_vSew  in  2  element width: 0=8b, 1=16b, 2=32b (3 reserved, treated as 2)
- req_sign  in  1  signed compare for min/max
- req_scalar  in  32  seed element (vs1[0]), low sew bits significant
- req_empty  in  1  no active elements; result = seed
- in_valid / in_ready  in / out  1  element-word handshake
- in_data  in  32  packed elements
- in_last  in  1  final word of command
- alu_src_0 / alu_src_1  out  32  ALU operands
- alu_opcode  out  4  latched opcode
- alu_vSew  out  2  latched sew
- alu_sign  out  1  latched sign
- alu_result  in  32  combinational ALU result
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  32  result, zero-extended above sew

## Operation
- States: IDLE, FIRST, ACCUM, FOLD, FINAL, DONE.
- IDLE: req_ready=1. On req_valid, latch opcode/sew/sign/scalar.
  - req_empty=1: go to FINAL with acc := scalar and fold count 0.
  - Otherwise: go to FIRST.
- FIRST: in_ready=1. On an accepted word, acc := in_data. No ALU use.
  - in_last=1: go to FOLD.
  - Otherwise: go to ACCUM.
- ACCUM: in_ready=1, alu_src_0=acc, alu_src_1=in_data. On an accepted word, acc := alu_result.
  - in_last=1: go to FOLD.
  - No in_valid: hold.
- FOLD: fold count loaded as sew8→2, sew16→1, sew32→0. A count of 0 goes straight to FINAL.
  - Step 1 (count 2 or 1): alu_src_1 = {16'h0, acc[31:16]}, acc := alu_result.
  - Step 2 (sew8 only): alu_src_1 = {24'h0, acc[15:8]}, acc := alu_result.
  - After the last step, go to FINAL.
- FINAL: alu_src_0=acc, alu_src_1=req_scalar latched. Then:
  - res := alu_result masked to sew (8b: [7:0], 16b: [15:0], 32b: all).
  - Empty case: res := scalar masked, no ALU.
  - Go to DONE.
- DONE: out_valid=1, out_data=res. On out_ready, go to IDLE. Data is held stable while stalled.
- alu_src_0/alu_src_1 are 0 in IDLE and DONE. alu_opcode/vSew/sign always reflect the latched values.
- in_last is ignored outside FIRST/ACCUM; in_ready=0 there.

## Timing
- Reset values: req_ready=1; in_ready=0; out_valid=0; out_data=0; alu_src_*=0; alu_opcode=0; alu_vSew=0; alu_sign=0; state IDLE; acc=0.
- Word throughput: 1 per cycle in FIRST/ACCUM.
- Cycles from last-word accept to out_valid: sew32 = 2, sew16 = 3, sew8 = 4 (fold steps + FINAL + DONE entry).
- Empty command: out_valid 2 cycles after req accept.
- Next req is accepted no earlier than the cycle after out handshake. No back-to-back overlap.
- Reset asserted mid-command: next cycle is IDLE with reset values. A partially consumed stream is abandoned, and the upstream source is flushed by the same reset.
- req_valid while not IDLE is ignored; req_ready=0.

## Configuration
- REDUCE_ACCUMULATOR_BUSYCNT_EN defined: adds output busy_cycles[15:0]. The counter clears on req accept and increments each cycle in FIRST through FINAL, saturating at 16'hFFFF. It holds its value until the next accept and resets to 0.
- Undefined: no port and no counter; behaviour otherwise identical.

## Test plan
- Add, sew32, words 5, 7, 9 (last), scalar 100 -> out_data=121, 2 cycles after last accept.
- Add, sew8, single word 32'h04030201, scalar 8'h0A -> out_data=32'h00000014, 4 cycles after accept.
- Signed min, sew16, words 32'h0005FFFE, 32'h7FFF0003, scalar 16'h0001 -> out_data=32'h0000FFFE.
- Empty command, scalar 32'hDEADBEEF, sew16 -> out_data=32'h0000BEEF; in_ready never high.
- in_valid gaps during ACCUM plus out_ready held low 5 cycles -> same result; out_data stable during the stall.
- Reset asserted in ACCUM after 2 words -> IDLE next cycle, out_valid=0. A new add command with one word 3 and scalar 4 gives 7.
